// File: rtl/spi_slave_if.sv
// Host-side handshake bundle for spi_slave: TX holding buffer in, RX word out,
// plus the status pulses and busy flag.
interface spi_slave_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  tx_underrun;
    logic                  rx_overrun;
    logic                  busy;

    modport slave (
        input  tx_data, tx_valid, rx_ready,
        output tx_ready, rx_data, rx_valid, tx_underrun, rx_overrun, busy
    );

    modport master (
        output tx_data, tx_valid, rx_ready,
        input  tx_ready, rx_data, rx_valid, tx_underrun, rx_overrun, busy
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave, mode 0 (CPOL=0, CPHA=0), MSB first, oversampled by axi_aclk.
// sclk/cs/mosi are resynchronized; all SPI activity is decoded from edges of
// the synchronized sclk. One-word TX holding buffer, one-word RX output register.
// DATA_WIDTH must be >= 2 and must match the interface's DATA_WIDTH.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic        axi_aclk,
    input  logic        axi_aresetn,
    input  logic        sclk,
    input  logic        cs,
    input  logic        mosi,
    output logic        miso,
    spi_slave_if.slave  bus
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
    logic                   sclk_q, cs_q;
    // Shift register of 1s after reset; the top bit says the cs synchronizer
    // now reflects the pin, so the preset->pin transition is not a real edge.
    logic [SYNC_STAGES:0]   sync_vld;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic start, stop, active_rise, active_fall, word_done, tx_take, tx_load;

    logic [DATA_WIDTH-1:0] shift_tx;
    logic [DATA_WIDTH-2:0] shift_rx;
    logic [DATA_WIDTH-1:0] rx_word;
    logic [CW-1:0]         bit_cnt;
    logic                  reload_pend;   // next falling edge reloads shift_tx
    logic                  urun_pend;     // zero-filled word reported at its first rise
    logic [DATA_WIDTH-1:0] tx_buf;
    logic                  tx_full;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  tx_underrun_q, rx_overrun_q;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_fall   = ~cs_s & cs_q & sync_vld[SYNC_STAGES];
    assign cs_rise   = cs_s & ~cs_q;

    // Input synchronizers and one-cycle-delayed copies for edge detection.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            sync_vld  <= '0;
        end else begin
            sclk_sync <= (sclk_sync << 1) | SYNC_STAGES'(sclk);
            cs_sync   <= (cs_sync << 1) | SYNC_STAGES'(cs);
            mosi_sync <= (mosi_sync << 1) | SYNC_STAGES'(mosi);
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
            sync_vld  <= {sync_vld[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // FSM state register.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // FSM next state plus frame start/stop strobes.
    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        stop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                    start   = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    stop    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A cs rise wins over an sclk edge in the same cycle: the frame is over.
    assign active_rise = (state_q == ACTIVE) && !stop && sclk_rise;
    assign active_fall = (state_q == ACTIVE) && !stop && sclk_fall;
    assign word_done   = active_rise && (bit_cnt == CW'(DATA_WIDTH - 1));
    assign tx_take     = start || (active_fall && reload_pend);
    assign tx_load     = bus.tx_valid && !tx_full;
    assign rx_word     = {shift_rx, mosi_s};

    // Datapath: TX buffer, shift registers, bit counter, RX register, pulses.
    // The reload after the last word of a frame still consumes the buffer;
    // an empty buffer there is only flagged as underrun if another bit starts.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            shift_tx      <= '0;
            shift_rx      <= '0;
            bit_cnt       <= '0;
            reload_pend   <= 1'b0;
            urun_pend     <= 1'b0;
            tx_buf        <= '0;
            tx_full       <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            rx_overrun_q  <= 1'b0;
        end else begin
            tx_underrun_q <= (start && !tx_full) || (active_rise && urun_pend);
            rx_overrun_q  <= 1'b0;

            if (tx_take)          shift_tx <= tx_full ? tx_buf : '0;
            else if (active_fall) shift_tx <= shift_tx << 1;

            if (stop || start)    reload_pend <= 1'b0;
            else if (word_done)   reload_pend <= 1'b1;
            else if (active_fall) reload_pend <= 1'b0;

            if (stop || start)                    urun_pend <= 1'b0;
            else if (active_fall && reload_pend)  urun_pend <= !tx_full;
            else if (active_rise)                 urun_pend <= 1'b0;

            if (tx_load) begin
                tx_buf  <= bus.tx_data;
                tx_full <= 1'b1;
            end else if (tx_take && tx_full) begin
                tx_full <= 1'b0;
            end

            if (stop || start) begin
                bit_cnt  <= '0;
                shift_rx <= '0;
            end else if (active_rise) begin
                shift_rx <= rx_word[DATA_WIDTH-2:0];
                bit_cnt  <= word_done ? '0 : bit_cnt + CW'(1);
            end

            if (word_done) begin
                if (!rx_valid_q || bus.rx_ready) begin
                    rx_data_q  <= rx_word;
                    rx_valid_q <= 1'b1;
                end else begin
                    rx_overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && bus.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign miso            = (state_q == ACTIVE) ? shift_tx[DATA_WIDTH-1] : 1'b0;
    assign bus.busy        = (state_q == ACTIVE);
    assign bus.tx_ready    = ~tx_full;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.rx_overrun  = rx_overrun_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: table of single-word transfers, hand-written burst,
// overrun, partial-word and mid-transfer-reset sequences, then random bursts
// checked against a word-level model of what master and host should see.
module tb_spi_slave;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int HALF = 8;   // sclk half period in axi_aclk cycles

    logic clk;
    logic axi_aresetn;
    logic sclk, cs, mosi, miso;

    spi_slave_if #(.DATA_WIDTH(DW)) bus ();

    spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
        .axi_aclk    (clk),
        .axi_aresetn (axi_aresetn),
        .sclk        (sclk),
        .cs          (cs),
        .mosi        (mosi),
        .miso        (miso),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Monitor state (written only by the monitor process)
    logic [7:0] rx_got[$];
    int         n_urun = 0;
    int         n_orun = 0;
    int         hold_bad = 0;
    int         miso_bad = 0;
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = '0;

    // Sample mid-cycle: host inputs change at posedge+2, DUT outputs at posedge.
    always @(negedge clk) begin
        if (axi_aresetn) begin
            if (bus.tx_underrun) n_urun++;
            if (bus.rx_overrun)  n_orun++;
            if (bus.rx_valid && bus.rx_ready) rx_got.push_back(bus.rx_data);
            if (hold_pend && (!bus.rx_valid || bus.rx_data !== hold_data)) hold_bad++;
            hold_pend = bus.rx_valid && !bus.rx_ready;
            hold_data = bus.rx_data;
            if (!bus.busy && miso !== 1'b0) miso_bad++;
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    function automatic logic [7:0] get_rx(input int i);
        if (i < rx_got.size()) return rx_got[i];
        return 8'hxx;
    endfunction

    task automatic tx_write(input logic [7:0] w);
        int t = 0;
        while (!bus.tx_ready && t < 400) begin
            tick(1);
            t++;
        end
        if (!bus.tx_ready) chk("tx_ready_timeout", 32'(bus.tx_ready), 32'd1);
        bus.tx_data  = w;
        bus.tx_valid = 1'b1;
        tick(1);
        bus.tx_valid = 1'b0;
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high();
        tick(HALF);
        cs = 1'b1;
        tick(HALF);
    endtask

    // Mode 0 master: mosi set with sclk low, miso sampled at the rising edge.
    task automatic spi_bits(input logic [7:0] w, input int n, output logic [7:0] got);
        got = '0;
        for (int i = 0; i < n; i++) begin
            mosi = w[7-i];
            tick(HALF);
            sclk = 1'b1;
            got  = {got[6:0], miso};
            tick(HALF);
            sclk = 1'b0;
        end
    endtask

    typedef struct {
        logic [7:0] mosi_w;
        logic [7:0] tx_w;
        bit         preload;
        logic [7:0] exp_miso;
        int         exp_urun;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [7:0] g, g0, g1;
        int u0, o0, base;

        vecs[0] = '{8'h55, 8'hA3, 1'b1, 8'hA3, 0};
        vecs[1] = '{8'h55, 8'h00, 1'b0, 8'h00, 1};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 0};
        vecs[3] = '{8'h00, 8'hFF, 1'b1, 8'hFF, 0};
        vecs[4] = '{8'h81, 8'h7E, 1'b1, 8'h7E, 0};

        axi_aresetn  = 1'b0;
        sclk         = 1'b0;
        cs           = 1'b1;
        mosi         = 1'b0;
        bus.tx_data  = '0;
        bus.tx_valid = 1'b0;
        bus.rx_ready = 1'b0;
        tick(3);
        chk("rst_miso", 32'(miso), 0);
        chk("rst_tx_ready", 32'(bus.tx_ready), 1);
        chk("rst_rx_valid", 32'(bus.rx_valid), 0);
        chk("rst_rx_data", 32'(bus.rx_data), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_pulses", 32'({bus.tx_underrun, bus.rx_overrun}), 0);
        axi_aresetn = 1'b1;
        tick(4);

        // Single-word transfers from the table
        for (int v = 0; v < 5; v++) begin
            u0 = n_urun;
            if (vecs[v].preload) begin
                tx_write(vecs[v].tx_w);
                chk("tbl_tx_full", 32'(bus.tx_ready), 0);
            end
            cs_low();
            chk("tbl_busy", 32'(bus.busy), 1);
            spi_bits(vecs[v].mosi_w, 8, g);
            cs_high();
            tick(2);
            chk("tbl_miso_word", 32'(g), 32'(vecs[v].exp_miso));
            chk("tbl_rx_valid", 32'(bus.rx_valid), 1);
            chk("tbl_rx_data", 32'(bus.rx_data), 32'(vecs[v].mosi_w));
            chk("tbl_underrun", 32'(n_urun - u0), 32'(vecs[v].exp_urun));
            chk("tbl_tx_ready", 32'(bus.tx_ready), 1);
            chk("tbl_idle", 32'(bus.busy), 0);
            bus.rx_ready = 1'b1;
            tick(1);
            bus.rx_ready = 1'b0;
            tick(1);
            chk("tbl_rx_clear", 32'(bus.rx_valid), 0);
        end

        // Two-word burst, second TX word written during the first word
        bus.rx_ready = 1'b1;
        base = rx_got.size();
        u0   = n_urun;
        tx_write(8'h12);
        cs_low();
        fork
            spi_bits(8'hAA, 8, g0);
            begin
                tick(4 * HALF);
                tx_write(8'h34);
            end
        join
        spi_bits(8'h0F, 8, g1);
        cs_high();
        tick(4);
        chk("burst_miso0", 32'(g0), 32'h12);
        chk("burst_miso1", 32'(g1), 32'h34);
        chk("burst_rx0", 32'(get_rx(base)), 32'hAA);
        chk("burst_rx1", 32'(get_rx(base + 1)), 32'h0F);
        chk("burst_rx_cnt", 32'(rx_got.size() - base), 2);
        chk("burst_underrun", 32'(n_urun - u0), 0);

        // Overrun: consumer stalled across two words
        bus.rx_ready = 1'b0;
        o0 = n_orun;
        cs_low();
        spi_bits(8'h11, 7, g);
        mosi = 1'b1;
        tick(HALF);
        sclk = 1'b1;
        tick(SYNC + 2);
        chk("rx_latency", 32'(bus.rx_valid), 1);
        chk("ovr_rx_first", 32'(bus.rx_data), 32'h11);
        tick(HALF - SYNC - 2);
        sclk = 1'b0;
        cs_high();
        cs_low();
        spi_bits(8'h22, 8, g);
        cs_high();
        tick(4);
        chk("ovr_rx_held", 32'(bus.rx_data), 32'h11);
        chk("ovr_valid_held", 32'(bus.rx_valid), 1);
        chk("ovr_pulses", 32'(n_orun - o0), 1);
        base = rx_got.size();
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
        tick(1);
        chk("ovr_accept", 32'(get_rx(base)), 32'h11);
        chk("ovr_clear", 32'(bus.rx_valid), 0);

        // Partial word (5 bits) aborted by cs, TX word written mid-word is kept
        bus.rx_ready = 1'b1;
        base = rx_got.size();
        o0   = n_orun;
        cs_low();
        fork
            spi_bits(8'hFF, 5, g);
            begin
                tick(2 * HALF);
                tx_write(8'hC5);
            end
        join
        cs_high();
        tick(10);
        chk("part_no_rx", 32'(rx_got.size() - base), 0);
        chk("part_rx_valid", 32'(bus.rx_valid), 0);
        chk("part_buf_kept", 32'(bus.tx_ready), 0);
        cs_low();
        spi_bits(8'h3C, 8, g);
        cs_high();
        tick(4);
        chk("part_full_rx", 32'(get_rx(base)), 32'h3C);
        chk("part_full_miso", 32'(g), 32'hC5);
        chk("part_overrun", 32'(n_orun - o0), 0);

        // Reset mid-word with cs held low
        tx_write(8'h77);
        cs_low();
        spi_bits(8'h96, 4, g);
        axi_aresetn = 1'b0;
        tick(2);
        chk("mrst_miso", 32'(miso), 0);
        chk("mrst_tx_ready", 32'(bus.tx_ready), 1);
        chk("mrst_rx_valid", 32'(bus.rx_valid), 0);
        chk("mrst_rx_data", 32'(bus.rx_data), 0);
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_pulses", 32'({bus.tx_underrun, bus.rx_overrun}), 0);
        axi_aresetn = 1'b1;
        base = rx_got.size();
        spi_bits(8'hFF, 4, g);
        tick(10);
        chk("mrst_stay_idle", 32'(bus.busy), 0);
        chk("mrst_no_rx", 32'(rx_got.size() - base), 0);
        cs_high();
        tx_write(8'h69);
        cs_low();
        spi_bits(8'h96, 8, g);
        cs_high();
        tick(4);
        chk("mrst_next_rx", 32'(get_rx(base)), 32'h96);
        chk("mrst_next_miso", 32'(g), 32'h69);

        // Random bursts against a word-level model
        for (int b = 0; b < 6; b++) begin
            int n, exp_urun;
            logic [7:0] mw[4], tw[4], gg[4];
            bit pres[4];
            n = $urandom_range(1, 4);
            exp_urun = 0;
            for (int k = 0; k < 4; k++) begin
                mw[k]   = 8'($urandom);
                tw[k]   = 8'($urandom);
                pres[k] = ($urandom_range(0, 3) != 0);
                if (k < n && !pres[k]) exp_urun++;
            end
            base = rx_got.size();
            u0   = n_urun;
            o0   = n_orun;
            if (pres[0]) tx_write(tw[0]);
            cs_low();
            for (int k = 0; k < n; k++) begin
                logic [7:0] cur_mw, cur_tw, got_w;
                bit wr_next;
                cur_mw  = mw[k];
                wr_next = (k + 1 < n) && pres[(k + 1) % 4];
                cur_tw  = tw[(k + 1) % 4];
                fork
                    spi_bits(cur_mw, 8, got_w);
                    begin
                        if (wr_next) begin
                            tick(4 * HALF);
                            tx_write(cur_tw);
                        end
                    end
                    begin
                        for (int c = 0; c < 150; c++) begin
                            bus.rx_ready = 1'($urandom_range(0, 1));
                            tick(1);
                        end
                        bus.rx_ready = 1'b1;
                    end
                join
                gg[k] = got_w;
            end
            cs_high();
            tick(4);
            for (int k = 0; k < n; k++) begin
                chk("rnd_miso", 32'(gg[k]), pres[k] ? 32'(tw[k]) : 32'h0);
                chk("rnd_rx", 32'(get_rx(base + k)), 32'(mw[k]));
            end
            chk("rnd_rx_cnt", 32'(rx_got.size() - base), 32'(n));
            chk("rnd_underrun", 32'(n_urun - u0), 32'(exp_urun));
            chk("rnd_overrun", 32'(n_orun - o0), 0);
            chk("rnd_tx_ready", 32'(bus.tx_ready), 1);
        end

        chk("rx_hold_violations", 32'(hold_bad), 0);
        chk("miso_idle_violations", 32'(miso_bad), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; the ports SHALL be named axi_aclk and axi_aresetn.
REQ-002 Parameter DATA_WIDTH, default 8: SPI word length in bits.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth for sclk, cs and mosi.
REQ-004 axi_aclk  in  1  system clock; all state SHALL be updated on its rising edge.
REQ-005 axi_aresetn  in  1  synchronous active-low reset.
REQ-006 sclk  in  1  SPI clock from the master; asynchronous to axi_aclk; CPOL=0, CPHA=0.
REQ-007 cs  in  1  active-low chip select from the master; asynchronous.
REQ-008 mosi  in  1  serial data from the master, MSB first.
REQ-009 miso  out  1  serial data to the master, MSB first.
REQ-010 tx_data  in  DATA_WIDTH  next word to transmit.
REQ-011 tx_valid  in  1  tx_data is valid.
REQ-012 tx_ready  out  1  TX holding buffer is empty; a word transfers when tx_valid and tx_ready are both high.
REQ-013 rx_data  out  DATA_WIDTH  last received word.
REQ-014 rx_valid  out  1  rx_data is valid; held high until rx_ready is high.
REQ-015 rx_ready  in  1  consumer accepts rx_data.
REQ-016 tx_underrun  out  1  one-cycle pulse: a word started with an empty TX buffer.
REQ-017 rx_overrun  out  1  one-cycle pulse: a word completed while rx_valid was still high.
REQ-018 busy  out  1  high while the FSM is in the ACTIVE state.

Function
REQ-019 sclk, cs and mosi SHALL each pass through a SYNC_STAGES flip-flop synchronizer; edges SHALL be detected on the synchronized sclk only.
REQ-020 sclk frequency SHALL NOT exceed axi_aclk/8; behaviour above this limit is undefined.
REQ-021 FSM states: IDLE and ACTIVE; IDLE->ACTIVE on synchronized cs falling; ACTIVE->IDLE on synchronized cs rising.
REQ-022 On IDLE->ACTIVE, shift_tx SHALL load the TX buffer and clear it if it is full; otherwise shift_tx SHALL load all zeros and tx_underrun SHALL pulse.
REQ-023 miso SHALL equal shift_tx MSB while ACTIVE and 0 while IDLE.
REQ-024 On each synchronized sclk rising edge while ACTIVE, mosi SHALL shift into shift_rx LSB and bit_cnt SHALL increment.
REQ-025 On each synchronized sclk falling edge while ACTIVE, shift_tx SHALL shift left by one and fill with 0.
REQ-026 When bit_cnt reaches DATA_WIDTH on a rising edge: bit_cnt SHALL wrap to 0 and the completed word SHALL go to the RX path.
REQ-027 RX path: if rx_valid is low or rx_ready is high that cycle, rx_data SHALL take the new word and rx_valid SHALL go high; otherwise the new word SHALL be dropped, rx_data held and rx_overrun pulsed.
REQ-028 rx_valid SHALL assert no more than SYNC_STAGES+2 axi_aclk cycles after the DATA_WIDTH-th sclk rising edge at the pin.
REQ-029 rx_valid SHALL clear the cycle after rx_valid and rx_ready are both high, unless a new word is written in that cycle.
REQ-030 Multi-word burst: on the falling edge that follows a word completion, shift_tx SHALL reload from the TX buffer, or from zeros with a tx_underrun pulse, instead of shifting.
REQ-031 tx_ready SHALL be the inverse of the TX-buffer-full flag; a buffer load and a buffer consume in the same cycle SHALL leave the buffer full with the new word.
REQ-032 cs rising mid-word SHALL discard the partial word: no rx_valid and no rx_overrun; bit_cnt SHALL clear; the TX buffer SHALL be kept.
REQ-033 Sclk edges seen while IDLE SHALL be ignored.

Reset
REQ-034 While axi_aresetn is low at a rising axi_aclk edge, the block SHALL apply: FSM=IDLE; miso=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, rx_overrun=0, busy=0; shift registers, bit_cnt and the TX buffer cleared; synchronizers preset to sclk=0, cs=1, mosi=0.
REQ-035 Reset asserted mid-transfer SHALL abort the word with no rx_valid; after reset release with cs still low, the block SHALL stay IDLE until the next cs falling edge.

Verification
REQ-036 Load tx_data=0xA3; master sends 0x55 -> rx_data=0x55, rx_valid high until rx_ready; master receives 0xA3; tx_ready returns high.
REQ-037 Two-word burst: master sends 0xAA,0x0F; tx 0x12 preloaded, 0x34 written during word 1 -> two rx_valid handshakes 0xAA,0x0F; master receives 0x12,0x34; no underrun.
REQ-038 TX buffer empty at cs falling; master sends 0x55 -> master receives 0x00, tx_underrun pulses once, rx_data=0x55.
REQ-039 rx_ready held low; master sends 0x11 then 0x22 -> rx_data stays 0x11, rx_overrun pulses once after word 2.
REQ-040 cs deasserted after 5 bits, then a full 0x3C transfer -> no rx_valid for the partial word; rx_data=0x3C after the full transfer.
REQ-041 axi_aresetn low for 2 cycles after bit 4 of a word -> all outputs at reset values; the next full transfer of 0x96 is received correctly.
